move_arbiter: RTL and testbench

Move scheduler and arbiter for the two player sprites on the 16×12 tile grid. It synchronizes raw direction buttons and turns held buttons into rate-limited, one-cycle move pulses aligned to the game tick. It also refuses moves that would leave the grid or put both sprites on the same tile. It sits between the board inputs and the two `movement` instances in `cross_road`, driving their `move_*` inputs and reading back their `player_x`/`player_y`.

---
 rtl/game_pkg.sv | 50 +++++
 rtl/player_move_fsm.sv | 95 +++++++++
 rtl/move_arbiter.sv | 104 ++++++++++
 tb/tb_move_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the cross_road move logic.
//   - Direction bit indices inside a 4-bit {up,down,left,right} vector.
//   - Default grid dimensions (16 x 12 tiles).
//   - Per-player move FSM state encoding.
//   - prio_dir():  fixed-priority (up > down > left > right) one-hot select.
//   - step_tile(): one-tile step from (x,y) in a direction, computed at 5 bits
//     so that stepping below 0 wraps to 31 and is caught by a range check.
//     Screen orientation: up decreases y, down increases y.
package game_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int GRID_W_DEFAULT = 16;
  localparam int GRID_H_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } move_state_t;

  function automatic logic [3:0] prio_dir(input logic [3:0] btn);
    logic [3:0] d;
    d = 4'b0000;
    if (btn[DIR_UP])         d[DIR_UP]    = 1'b1;
    else if (btn[DIR_DOWN])  d[DIR_DOWN]  = 1'b1;
    else if (btn[DIR_LEFT])  d[DIR_LEFT]  = 1'b1;
    else if (btn[DIR_RIGHT]) d[DIR_RIGHT] = 1'b1;
    return d;
  endfunction

  // Returns {tx, ty}, each 5 bits wide.
  function automatic logic [9:0] step_tile(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic [3:0] dir);
    logic [4:0] tx;
    logic [4:0] ty;
    tx = {1'b0, x};
    ty = {1'b0, y};
    if (dir[DIR_UP])    ty = ty - 5'd1;
    if (dir[DIR_DOWN])  ty = ty + 5'd1;
    if (dir[DIR_LEFT])  tx = tx - 5'd1;
    if (dir[DIR_RIGHT]) tx = tx + 5'd1;
    return {tx, ty};
  endfunction

endpackage

// File: rtl/player_move_fsm.sv
// player_move_fsm: per-player button synchronizer, priority encoder and
// IDLE/ARMED/HOLD repeat FSM.
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   tick         one-cycle game-tick strobe
//   freeze       forces IDLE, clears counter, suppresses attempts
//   btn[3:0]     raw {up,down,left,right} buttons (asynchronous)
//   granted      same-cycle answer from the arbiter to this cycle's attempt
//   attempt      high in a tick cycle when a move is being tried
//   dir[3:0]     one-hot requested direction (0 when nothing held)
//   state        current FSM state (debug visibility)
//
// Handshake: attempt acts as a single-cycle valid that only ever rises in a
// tick cycle; there is no ready/backpressure. granted is a combinational
// response valid only while attempt is high, and is ignored otherwise.
module player_move_fsm
  import game_pkg::*;
#(
  parameter int HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        freeze,
  input  logic [3:0]  btn,
  input  logic        granted,
  output logic        attempt,
  output logic [3:0]  dir,
  output move_state_t state
);

  localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TICKS - 1);

  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  last_dir;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  move_state_t state_n;
  logic        req;
  logic        dir_changed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 4'b0000;
      sync2    <= 4'b0000;
      last_dir <= 4'b0000;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      last_dir <= dir;
      state    <= state_n;
      cnt      <= cnt_n;
    end
  end

  assign dir         = prio_dir(sync2);
  assign req         = |sync2;
  assign dir_changed = (dir != last_dir);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    attempt = 1'b0;
    if (freeze || !req) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      // A fresh press only arms; the first attempt waits for a later tick.
      state_n = ARMED;
      cnt_n   = '0;
    end else if (state == ARMED || dir_changed) begin
      // A direction change while holding behaves exactly like ARMED, so a
      // tick in that same cycle already tries the new direction.
      state_n = ARMED;
      cnt_n   = '0;
      if (tick) begin
        attempt = 1'b1;
        state_n = granted ? HOLD : ARMED;
      end
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        attempt = 1'b1;
        cnt_n   = '0;
        state_n = granted ? HOLD : ARMED;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_arbiter.sv
// move_arbiter: schedules and arbitrates tile moves for two player sprites.
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   tick                      one-cycle game tick (ticks >= 2 cycles apart)
//   freeze                    pause/game over: no moves, FSMs to IDLE
//   p1_btn, p2_btn [3:0]      raw {up,down,left,right} buttons
//   p1_x/p1_y, p2_x/p2_y [3:0] current tiles reported by the movement blocks
//   p1_move, p2_move [3:0]    one-cycle one-hot move pulse, cycle after tick
//   p1_blocked, p2_blocked    one-cycle pulse when an attempt is refused
//   rr_p2                     1: player 2 wins the next same-tile conflict
//   p1_state, p2_state        per-player FSM state (debug visibility)
module move_arbiter
  import game_pkg::*;
#(
  parameter int HOLD_TICKS = 8,
  parameter int GRID_W     = GRID_W_DEFAULT,
  parameter int GRID_H     = GRID_H_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        freeze,
  input  logic [3:0]  p1_btn,
  input  logic [3:0]  p2_btn,
  input  logic [3:0]  p1_x,
  input  logic [3:0]  p1_y,
  input  logic [3:0]  p2_x,
  input  logic [3:0]  p2_y,
  output logic [3:0]  p1_move,
  output logic [3:0]  p2_move,
  output logic        p1_blocked,
  output logic        p2_blocked,
  output logic        rr_p2,
  output move_state_t p1_state,
  output move_state_t p2_state
);

  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

  logic       a1, a2;
  logic       g1, g2;
  logic [3:0] d1, d2;
  logic [4:0] t1x, t1y, t2x, t2y;
  logic       ok1, ok2;
  logic       conflict;

  player_move_fsm #(.HOLD_TICKS(HOLD_TICKS)) u_p1 (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .freeze  (freeze),
    .btn     (p1_btn),
    .granted (g1),
    .attempt (a1),
    .dir     (d1),
    .state   (p1_state)
  );

  player_move_fsm #(.HOLD_TICKS(HOLD_TICKS)) u_p2 (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .freeze  (freeze),
    .btn     (p2_btn),
    .granted (g2),
    .attempt (a2),
    .dir     (d2),
    .state   (p2_state)
  );

  assign {t1x, t1y} = step_tile(p1_x, p1_y, d1);
  assign {t2x, t2y} = step_tile(p2_x, p2_y, d2);

  // Underflow wraps to 31, so a single upper-bound compare covers both
  // edges. The other player's tile counts as occupied even if that player
  // is leaving it this same tick, which makes a head-on swap fail for both.
  assign ok1 = a1 && (t1x <= X_MAX) && (t1y <= Y_MAX) &&
               !((t1x == {1'b0, p2_x}) && (t1y == {1'b0, p2_y}));
  assign ok2 = a2 && (t2x <= X_MAX) && (t2y <= Y_MAX) &&
               !((t2x == {1'b0, p1_x}) && (t2y == {1'b0, p1_y}));

  assign conflict = ok1 && ok2 && (t1x == t2x) && (t1y == t2y);

  assign g1 = ok1 && !(conflict && rr_p2);
  assign g2 = ok2 && !(conflict && !rr_p2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_move    <= 4'b0000;
      p2_move    <= 4'b0000;
      p1_blocked <= 1'b0;
      p2_blocked <= 1'b0;
      rr_p2      <= 1'b0;
    end else begin
      p1_move    <= g1 ? d1 : 4'b0000;
      p2_move    <= g2 ? d2 : 4'b0000;
      p1_blocked <= a1 && !g1;
      p2_blocked <= a2 && !g2;
      rr_p2      <= rr_p2 ^ conflict;
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: randomized and directed stimulus for move_arbiter with a
// behavioural reference model (positions, tick counting, arbitration rules)
// checked every cycle, plus directed scenario checks.
module tb_move_arbiter;
  import game_pkg::*;

  localparam int HT = 2;
  localparam int GW = 16;
  localparam int GH = 12;

  logic        clk, rst, tick, freeze;
  logic [3:0]  p1_btn, p2_btn, p1_x, p1_y, p2_x, p2_y;
  logic [3:0]  p1_move, p2_move;
  logic        p1_blocked, p2_blocked, rr_p2;
  move_state_t p1_state, p2_state;

  move_arbiter #(.HOLD_TICKS(HT), .GRID_W(GW), .GRID_H(GH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .freeze     (freeze),
    .p1_btn     (p1_btn),
    .p2_btn     (p2_btn),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .p1_move    (p1_move),
    .p2_move    (p2_move),
    .p1_blocked (p1_blocked),
    .p2_blocked (p2_blocked),
    .rr_p2      (rr_p2),
    .p1_state   (p1_state),
    .p2_state   (p2_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_checks, n_fail;
  // model: 0 = idle, 1 = armed, 2 = holding
  int         st[2], cnt[2], last[2], px[2], py[2];
  logic [3:0] ms1[2], ms2[2], b[2], e_move[2], first_mv[2];
  bit         e_blk[2], m_rr;
  int         mv[2], bk[2];
  bit         tick_en, frz_i, rand_per;
  int         tick_cnt, tick_per;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      st[p] = 0; cnt[p] = 0; last[p] = -1;
      ms1[p] = 4'b0; ms2[p] = 4'b0;
      e_move[p] = 4'b0; e_blk[p] = 1'b0;
    end
    m_rr = 1'b0;
  endtask

  // Predicts outputs produced by the coming rising edge.
  task automatic model_step(input bit tk);
    int req[2], tx[2], ty[2];
    bit att[2], ok[2];
    for (int p = 0; p < 2; p++) begin
      logic [3:0] v;
      v = ms2[p];  // buttons as seen two edges late
      req[p] = v[3] ? 3 : v[2] ? 2 : v[1] ? 1 : v[0] ? 0 : -1;
      ms2[p] = ms1[p];
      ms1[p] = b[p];
      att[p] = 1'b0;
      if (frz_i || req[p] < 0) begin
        st[p] = 0; cnt[p] = 0;
      end else if (st[p] == 0) begin
        st[p] = 1; cnt[p] = 0;
      end else if (st[p] == 1 || req[p] != last[p]) begin
        st[p] = 1; cnt[p] = 0; att[p] = tk;
      end else if (tk) begin
        if (cnt[p] == HT - 1) begin
          att[p] = 1'b1; cnt[p] = 0;
        end else begin
          cnt[p]++;
        end
      end
      last[p] = req[p];
      tx[p] = px[p]; ty[p] = py[p];
      case (req[p])
        3: ty[p] = py[p] - 1;
        2: ty[p] = py[p] + 1;
        1: tx[p] = px[p] - 1;
        0: tx[p] = px[p] + 1;
        default: ;
      endcase
    end
    for (int p = 0; p < 2; p++)
      ok[p] = att[p] && tx[p] >= 0 && tx[p] < GW && ty[p] >= 0 && ty[p] < GH &&
              !(tx[p] == px[1-p] && ty[p] == py[1-p]);
    if (ok[0] && ok[1] && tx[0] == tx[1] && ty[0] == ty[1]) begin
      if (m_rr) ok[0] = 1'b0;
      else      ok[1] = 1'b0;
      m_rr = !m_rr;
    end
    for (int p = 0; p < 2; p++) begin
      if (att[p]) st[p] = ok[p] ? 2 : 1;
      e_move[p] = ok[p] ? 4'(1 << req[p]) : 4'b0;
      e_blk[p]  = att[p] && !ok[p];
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_step();
    bit tk;
    tk = 1'b0;
    if (tick_en) begin
      tick_cnt++;
      if (tick_cnt >= tick_per) begin
        tk = 1'b1;
        tick_cnt = 0;
        if (rand_per) tick_per = $urandom_range(2, 6);
      end
    end
    tick   = tk;
    freeze = frz_i;
    p1_btn = b[0];
    p2_btn = b[1];
    p1_x = 4'(px[0]); p1_y = 4'(py[0]);
    p2_x = 4'(px[1]); p2_y = 4'(py[1]);
    model_step(tk);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_eq("p1_move",    32'(p1_move),    32'(e_move[0]));
    check_eq("p2_move",    32'(p2_move),    32'(e_move[1]));
    check_eq("p1_blocked", 32'(p1_blocked), 32'(e_blk[0]));
    check_eq("p2_blocked", 32'(p2_blocked), 32'(e_blk[1]));
    check_eq("rr_p2",      32'(rr_p2),      32'(m_rr));
    check_eq("p1_state",   32'(p1_state),   32'(st[0]));
    check_eq("p2_state",   32'(p2_state),   32'(st[1]));
    if (p1_move != 4'b0) begin if (mv[0] == 0) first_mv[0] = p1_move; mv[0]++; end
    if (p2_move != 4'b0) begin if (mv[1] == 0) first_mv[1] = p2_move; mv[1]++; end
    if (p1_blocked) bk[0]++;
    if (p2_blocked) bk[1]++;
    // movement block: apply granted moves before the next tick
    for (int p = 0; p < 2; p++) begin
      if (e_move[p][3]) py[p]--;
      if (e_move[p][2]) py[p]++;
      if (e_move[p][1]) px[p]--;
      if (e_move[p][0]) px[p]++;
    end
    drive_step();
  endtask

  task automatic clear_counts();
    for (int p = 0; p < 2; p++) begin
      mv[p] = 0; bk[p] = 0; first_mv[p] = 4'b0;
    end
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_p1_move",    32'(p1_move),    32'h0);
    check_eq("rst_p2_move",    32'(p2_move),    32'h0);
    check_eq("rst_p1_blocked", 32'(p1_blocked), 32'h0);
    check_eq("rst_p2_blocked", 32'(p2_blocked), 32'h0);
    check_eq("rst_rr_p2",      32'(rr_p2),      32'h0);
    check_eq("rst_p1_state",   32'(p1_state),   32'(IDLE));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_step();
  endtask

  // Release, place players, press buttons, let them arm, then run nt ticks
  // spaced 4 cycles apart and observe the pulse after the last one.
  task automatic scenario(input int x1, input int y1, input logic [3:0] b1,
                          input int x2, input int y2, input logic [3:0] b2,
                          input int nt);
    tick_en = 1'b0;
    b[0] = 4'b0; b[1] = 4'b0;
    repeat (4) cycle();
    px[0] = x1; py[0] = y1; px[1] = x2; py[1] = y2;
    b[0] = b1; b[1] = b2;
    repeat (4) cycle();
    clear_counts();
    tick_cnt = 0; tick_per = 4; tick_en = 1'b1;
    repeat (nt * 4 + 1) cycle();
    tick_en = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; tick = 1'b0; freeze = 1'b0;
    p1_btn = 4'b0; p2_btn = 4'b0;
    p1_x = 4'd0; p1_y = 4'd0; p2_x = 4'd0; p2_y = 4'd0;
    b[0] = 4'b0; b[1] = 4'b0; frz_i = 1'b0;
    tick_en = 1'b0; tick_cnt = 0; tick_per = 4; rand_per = 1'b0;
    px[0] = 4; py[0] = 4; px[1] = 10; py[1] = 10;
    clear_counts();
    model_reset();
    apply_reset();

    // held up, HOLD_TICKS=2: moves on ticks 1, 3, 5
    scenario(4, 4, 4'b1000, 10, 10, 4'b0000, 5);
    check_eq("hold_up_moves", 32'(mv[0]), 32'd3);
    check_eq("hold_up_dir",   32'(first_mv[0]), 32'h8);
    check_eq("hold_up_blk",   32'(bk[0]), 32'd0);

    // left edge: refused every tick, never moves
    scenario(0, 5, 4'b0010, 10, 10, 4'b0000, 3);
    check_eq("edge_left_moves", 32'(mv[0]), 32'd0);
    check_eq("edge_left_blk",   32'(bk[0]), 32'd3);

    // same-tile conflict, rr_p2 = 0 -> P1 wins, pointer toggles
    apply_reset();
    scenario(3, 3, 4'b0001, 5, 3, 4'b0010, 1);
    check_eq("conf1_p1_move", 32'(first_mv[0]), 32'h1);
    check_eq("conf1_p2_blk",  32'(bk[1]), 32'd1);
    check_eq("conf1_rr",      32'(rr_p2), 32'd1);
    // repeat: P2 wins
    scenario(3, 3, 4'b0001, 5, 3, 4'b0010, 1);
    check_eq("conf2_p2_move", 32'(first_mv[1]), 32'h2);
    check_eq("conf2_p1_blk",  32'(bk[0]), 32'd1);
    check_eq("conf2_rr",      32'(rr_p2), 32'd0);

    // swap: both refused, pointer untouched
    scenario(3, 3, 4'b0001, 4, 3, 4'b0010, 1);
    check_eq("swap_p1_blk", 32'(bk[0]), 32'd1);
    check_eq("swap_p2_blk", 32'(bk[1]), 32'd1);
    check_eq("swap_moves",  32'(mv[0] + mv[1]), 32'd0);
    check_eq("swap_rr",     32'(rr_p2), 32'd0);

    // freeze before the tick, then release
    tick_en = 1'b0; b[0] = 4'b0; b[1] = 4'b0;
    repeat (4) cycle();
    px[0] = 2; py[0] = 2; px[1] = 10; py[1] = 10;
    frz_i = 1'b1; b[0] = 4'b0100;
    repeat (4) cycle();
    clear_counts();
    tick_cnt = 0; tick_per = 4; tick_en = 1'b1;
    repeat (8) cycle();
    check_eq("frz_pulses", 32'(mv[0] + bk[0]), 32'd0);
    frz_i = 1'b0;
    clear_counts();
    tick_cnt = 0;
    repeat (5) cycle();
    check_eq("unfrz_moves", 32'(mv[0]), 32'd1);
    check_eq("unfrz_dir",   32'(first_mv[0]), 32'h4);

    // reset the cycle after a granting tick
    tick_en = 1'b0; b[0] = 4'b0;
    repeat (4) cycle();
    px[0] = 4; py[0] = 6;
    b[0] = 4'b1000;
    repeat (4) cycle();
    tick_cnt = 0; tick_per = 4; tick_en = 1'b1;
    repeat (5) cycle();
    check_eq("pre_rst_move", 32'(p1_move), 32'h8);
    apply_reset();
    check_eq("post_rst_state", 32'(p1_state), 32'(IDLE));

    // randomized play
    px[0] = 6; py[0] = 6; px[1] = 8; py[1] = 6;
    rand_per = 1'b1; tick_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0:       b[p] = 4'b0;
            1, 2:    b[p] = 4'(1 << $urandom_range(0, 3));
            default: b[p] = 4'($urandom_range(0, 15));
          endcase
        end
      end
      if (frz_i) begin
        if ($urandom_range(0, 7) == 0) frz_i = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        frz_i = 1'b1;
      end
      cycle();
    end
    tick_en = 1'b0; frz_i = 1'b0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
